mmio_controller_hs: RTL and testbench
=====================================

Name: mmio_controller_hs

Overview:
- Parametrised, handshaked successor to the flat MMIO decoder between the FPro bridge and peripheral cores.
- Registers each bus access, presents it to exactly one slot, and holds the slot strobes until that slot acks or a timeout expires.
- Returns a registered read-data/ready/error response to the bridge.
- Adds wait-state support, out-of-range and illegal-op detection, and a bus timeout.

Parameters:
- NUM_SLOTS, 64, number of slots; 1..64, need not be a power of two.
- REG_AW, 5, register address width inside a slot.
- DW, 32, data width.
- ADDR_W, 21, bridge address width.
- TIMEOUT, 255, max ACCESS cycles before error; >=1.
- SLOT_AW (localparam), max(1,$clog2(NUM_SLOTS)).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mmio_cs  in  1  bridge access request.
- mmio_address  in  ADDR_W  reg = [REG_AW-1:0], slot = [REG_AW +: SLOT_AW], higher bits ignored.
- mmio_write_data  in  DW  write data.
- mmio_write  in  1  write op.
- mmio_read  in  1  read op.
- mmio_read_data  out  DW  registered read response.
- mmio_ready  out  1  one-cycle response strobe.
- mmio_error  out  1  qualifies mmio_ready; access failed.
- slot_cs  out  NUM_SLOTS  one-hot slot select.
- slot_reg_addr  out  REG_AW  latched register address, shared by all slots.
- slot_write_data  out  DW  latched write data, shared.
- slot_write  out  1  write strobe, shared, valid only with slot_cs.
- slot_read  out  1  read strobe, shared, valid only with slot_cs.
- slot_read_data  in  NUM_SLOTS x DW  per-slot read data.
- slot_ack  in  NUM_SLOTS  per-slot completion; sampled only for the selected slot.

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE next edge. All outputs 0: slot_cs, slot_write, slot_read, slot_reg_addr, slot_write_data, mmio_read_data, mmio_ready, mmio_error. Timeout counter 0.
- Reset mid-access: strobes drop at the next edge. No response is produced for the aborted access.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, mmio_cs=1 with exactly one of read/write:
  - latch reg addr, slot index, write data, op.
  - if slot index < NUM_SLOTS -> ACCESS.
  - else -> RESP with error=1, no slot strobes.
- IDLE, mmio_cs=1 with read=write=1: -> RESP with error=1, no slot access.
- IDLE, mmio_cs=1 with read=write=0: ignored, stay IDLE.
- ACCESS:
  - slot_cs[idx]=1 and the matching slot_read/slot_write=1, held every cycle until exit.
  - counter starts at 0 on entry and increments each cycle with no ack.
  - slot_ack[idx]=1 -> RESP, error=0. For a read, capture slot_read_data[idx].
  - no ack and counter==TIMEOUT-1 -> RESP, error=1. ACCESS therefore lasts at most TIMEOUT cycles.
  - ack on the final timeout cycle counts as success.
  - acks from non-selected slots are ignored.
- RESP:
  - mmio_ready=1 for exactly one cycle, then -> IDLE.
  - slot_cs, slot_read, slot_write are 0.
  - mmio_error is valid with ready and 0 otherwise.
- mmio_read_data: loaded on entry to RESP. Captured data for a successful read; 0 for a write or any error. Holds that value until the next RESP.
- Busy: mmio_cs in ACCESS or RESP is ignored; no queuing. The bridge must hold off until ready.
- Latency, request sample to mmio_ready: minimum 3 edges (IDLE->ACCESS, ack in first ACCESS cycle ->RESP, ready). Error paths: 2.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP.

Test Plan:
- Reset: drive reset for 2 cycles with mmio_cs=1, read=1 -> all outputs 0. FSM idle; first access is accepted only after reset drops.
- Write, zero wait: addr=0x0A3 (slot 5, reg 3), data=0xDEADBEEF, write=1; slot 5 acks in its first ACCESS cycle -> slot_cs=1<<5, slot_write=1, slot_reg_addr=3, slot_write_data=0xDEADBEEF for 1 cycle. mmio_ready=1, error=0, read_data=0 on edge 3.
- Read, 4 wait states: addr=0x7E1 (slot 63, reg 1); slot 63 returns 0x12345678 with ack on its 5th ACCESS cycle -> slot_read held 5 cycles. mmio_read_data=0x12345678, ready=1, error=0.
- Timeout: TIMEOUT=8, read slot 2, no ack -> strobes held exactly 8 cycles, then ready=1, error=1, read_data=0. Repeat with ack on cycle 8 -> success.
- Range/illegal: NUM_SLOTS=40, access slot 45 -> no slot_cs, ready+error after 2 edges. read=write=1 on a valid slot -> same. mmio_cs with no op -> no response.
- Busy/abort: second mmio_cs during ACCESS -> ignored, single response. Reset asserted during ACCESS -> strobes 0 next edge, no ready.

Source files
------------

// File: rtl/mmio_controller_hs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_controller_hs
// Brief    : Handshaked MMIO slot controller with wait states, range/op
//            checking and a bus timeout between the FPro bridge and cores.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_controller_hs #(
    parameter int NUM_SLOTS = 64,
    parameter int REG_AW    = 5,
    parameter int DW        = 32,
    parameter int ADDR_W    = 21,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mmio_cs,
    input  logic [ADDR_W-1:0]             mmio_address,
    input  logic [DW-1:0]                 mmio_write_data,
    input  logic                          mmio_write,
    input  logic                          mmio_read,
    output logic [DW-1:0]                 mmio_read_data,
    output logic                          mmio_ready,
    output logic                          mmio_error,
    output logic [NUM_SLOTS-1:0]          slot_cs,
    output logic [REG_AW-1:0]             slot_reg_addr,
    output logic [DW-1:0]                 slot_write_data,
    output logic                          slot_write,
    output logic                          slot_read,
    input  logic [NUM_SLOTS-1:0][DW-1:0]  slot_read_data,
    input  logic [NUM_SLOTS-1:0]          slot_ack
);

    localparam int SLOT_AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]           r_state;
    logic [SLOT_AW-1:0]   r_slot_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic [DW-1:0]        r_read_data;
    logic                 r_ready;
    logic                 r_error;
    logic [NUM_SLOTS-1:0] r_slot_cs;
    logic [REG_AW-1:0]    r_slot_reg_addr;
    logic [DW-1:0]        r_slot_write_data;
    logic                 r_slot_write;
    logic                 r_slot_read;

    logic [SLOT_AW-1:0]   w_slot_idx;
    logic                 w_in_range;
    logic [NUM_SLOTS-1:0] w_slot_onehot;
    logic                 w_sel_ack;
    logic [DW-1:0]        w_sel_data;

    assign w_slot_idx = mmio_address[REG_AW +: SLOT_AW];
    assign w_in_range = ({{(32-SLOT_AW){1'b0}}, w_slot_idx} < 32'(NUM_SLOTS));

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_onehot
        assign w_slot_onehot[gi] = (w_slot_idx == SLOT_AW'(gi));
    end

    if (ADDR_W > REG_AW + SLOT_AW) begin : g_high_addr
        logic w_unused_high;
        assign w_unused_high = ^mmio_address[ADDR_W-1:REG_AW+SLOT_AW];
    end

    // Explicit mux keeps non-existent slot indices from reading undefined bits.
    always_comb begin
        w_sel_ack  = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_slot_idx == SLOT_AW'(i)) begin
                w_sel_ack  = slot_ack[i];
                w_sel_data = slot_read_data[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_slot_idx        <= '0;
            r_cnt             <= '0;
            r_err             <= 1'b0;
            r_read_data       <= '0;
            r_ready           <= 1'b0;
            r_error           <= 1'b0;
            r_slot_cs         <= '0;
            r_slot_reg_addr   <= '0;
            r_slot_write_data <= '0;
            r_slot_write      <= 1'b0;
            r_slot_read       <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mmio_cs) begin
                        if (mmio_read ^ mmio_write) begin
                            r_slot_reg_addr   <= mmio_address[REG_AW-1:0];
                            r_slot_idx        <= w_slot_idx;
                            r_slot_write_data <= mmio_write_data;
                            if (w_in_range) begin
                                r_slot_cs    <= w_slot_onehot;
                                r_slot_read  <= mmio_read;
                                r_slot_write <= mmio_write;
                                r_cnt        <= '0;
                                r_state      <= S_ACCESS;
                            end else begin
                                r_err       <= 1'b1;
                                r_read_data <= '0;
                                r_state     <= S_RESP;
                            end
                        end else if (mmio_read) begin
                            r_err       <= 1'b1;
                            r_read_data <= '0;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (w_sel_ack || (r_cnt == c_cnt_last)) begin
                        r_err        <= ~w_sel_ack;
                        r_read_data  <= (w_sel_ack && r_slot_read) ? w_sel_data : '0;
                        r_slot_cs    <= '0;
                        r_slot_read  <= 1'b0;
                        r_slot_write <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_error <= r_err;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mmio_read_data  = r_read_data;
    assign mmio_ready      = r_ready;
    assign mmio_error      = r_error;
    assign slot_cs         = r_slot_cs;
    assign slot_reg_addr   = r_slot_reg_addr;
    assign slot_write_data = r_slot_write_data;
    assign slot_write      = r_slot_write;
    assign slot_read       = r_slot_read;

endmodule
`default_nettype wire

// File: tb/tb_mmio_controller_hs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mmio_controller_hs
// Brief    : Self-checking bench for mmio_controller_hs (64-slot and 40-slot
//            instances, TIMEOUT=8) with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_controller_hs;

    localparam int TOUT = 8;

    logic                clock = 1'b0;
    logic                reset;
    logic                mmio_cs;
    logic [20:0]         mmio_address;
    logic [31:0]         mmio_write_data;
    logic                mmio_write;
    logic                mmio_read;
    logic [63:0]         slot_ack;
    logic [63:0][31:0]   slot_rd;

    logic [31:0]         mmio_read_data;
    logic                mmio_ready;
    logic                mmio_error;
    logic [63:0]         slot_cs;
    logic [4:0]          slot_reg_addr;
    logic [31:0]         slot_write_data;
    logic                slot_write;
    logic                slot_read;

    logic [31:0]         rd40;
    logic                rdy40;
    logic                err40;
    logic [39:0]         cs40;
    logic [4:0]          reg40;
    logic [31:0]         wd40;
    logic                w40;
    logic                r40;

    always #5 clock = ~clock;

    mmio_controller_hs #(.NUM_SLOTS(64), .REG_AW(5), .DW(32), .ADDR_W(21), .TIMEOUT(TOUT)) dut (
        .clock(clock), .reset(reset), .mmio_cs(mmio_cs), .mmio_address(mmio_address),
        .mmio_write_data(mmio_write_data), .mmio_write(mmio_write), .mmio_read(mmio_read),
        .mmio_read_data(mmio_read_data), .mmio_ready(mmio_ready), .mmio_error(mmio_error),
        .slot_cs(slot_cs), .slot_reg_addr(slot_reg_addr), .slot_write_data(slot_write_data),
        .slot_write(slot_write), .slot_read(slot_read), .slot_read_data(slot_rd),
        .slot_ack(slot_ack)
    );

    mmio_controller_hs #(.NUM_SLOTS(40), .REG_AW(5), .DW(32), .ADDR_W(21), .TIMEOUT(TOUT)) dut40 (
        .clock(clock), .reset(reset), .mmio_cs(mmio_cs), .mmio_address(mmio_address),
        .mmio_write_data(mmio_write_data), .mmio_write(mmio_write), .mmio_read(mmio_read),
        .mmio_read_data(rd40), .mmio_ready(rdy40), .mmio_error(err40),
        .slot_cs(cs40), .slot_reg_addr(reg40), .slot_write_data(wd40),
        .slot_write(w40), .slot_read(r40), .slot_read_data(slot_rd[39:0]),
        .slot_ack(slot_ack[39:0])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [20:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rd;
        logic [31:0] sdata;
        int          ack_cyc;
        int          wrong_ack;
        bit          poke;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
        bit          exp_resp;
    } vec_t;

    resp_t q[$];
    resp_t q40[$];
    bit    check40 = 1'b0;
    bit    started = 1'b0;
    int    checks  = 0;
    int    errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response scoreboards
    always @(negedge clock) begin
        resp_t e;
        if (started) begin
            if (mmio_ready === 1'b1) begin
                if (q.size() == 0) check("ready_without_pending", mmio_ready, 64'd0);
                else begin
                    e = q.pop_front();
                    check("resp_error", mmio_error, e.err);
                    check("resp_rdata", mmio_read_data, e.rdata);
                end
            end else begin
                check("error_without_ready", mmio_error, 64'd0);
            end
            if (check40 && rdy40 === 1'b1) begin
                if (q40.size() == 0) check("ready40_without_pending", rdy40, 64'd0);
                else begin
                    e = q40.pop_front();
                    check("resp40_error", err40, e.err);
                    check("resp40_rdata", rd40, e.rdata);
                end
            end
        end
    end

    task automatic idle_inputs();
        mmio_cs = 1'b0; mmio_read = 1'b0; mmio_write = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [5:0]  idx;
        logic [63:0] oh;
        int          ncyc;
        ncyc = 0;
        idx  = v.addr[10:5];
        oh   = 64'd1 << idx;
        slot_rd[idx] = v.sdata;
        @(posedge clock); #1;
        mmio_cs = 1'b1; mmio_address = v.addr; mmio_write_data = v.wdata;
        mmio_write = v.wr; mmio_read = v.rd;
        if (v.exp_resp) q.push_back('{v.exp_rdata, v.exp_err});
        for (int c = 1; c <= TOUT + 3; c++) begin
            @(posedge clock); #1;
            if (c == 1 && v.poke) begin
                mmio_cs = 1'b1; mmio_address = 21'h0C0; mmio_write = 1'b1; mmio_read = 1'b0;
            end else begin
                idle_inputs();
            end
            slot_ack = '0;
            if (v.wrong_ack >= 0) slot_ack[v.wrong_ack] = 1'b1;
            if (c == v.ack_cyc) slot_ack[idx] = 1'b1;
            @(negedge clock);
            if (slot_cs == '0) break;
            ncyc++;
            check("slot_cs", slot_cs, oh);
            check("slot_read", slot_read, v.rd);
            check("slot_write", slot_write, v.wr);
            check("slot_reg_addr", slot_reg_addr, v.addr[4:0]);
            check("slot_write_data", slot_write_data, v.wdata);
        end
        slot_ack = '0;
        check("access_cycles", ncyc, v.exp_cyc);
        repeat (4) @(posedge clock);
        check("resp_drained", q.size(), 0);
    endtask

    // Two-edge error path on the 40-slot instance; the 64-slot one is also fed.
    task automatic range_case(input logic [20:0] addr, input logic wr, input logic rd,
                              input logic exp_err64, input int drain);
        @(posedge clock); #1;
        mmio_cs = 1'b1; mmio_address = addr; mmio_write = wr; mmio_read = rd;
        mmio_write_data = 32'h0000_0001;
        q40.push_back('{32'h0, 1'b1});
        q.push_back('{32'h0, exp_err64});
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        check("r40_cs_edge1", cs40, 40'h0);
        check("r40_ready_edge1", rdy40, 64'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("r40_cs_edge2", cs40, 40'h0);
        check("r40_ready_edge2", rdy40, 64'd1);
        check("r40_error_edge2", err40, 64'd1);
        repeat (drain) @(posedge clock);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{21'h0A3,    32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1, -1, 1'b0, 1, 1'b0, 32'h0,        1'b1};
        vecs[1] = '{21'h7E1,    32'h0,        1'b0, 1'b1, 32'h12345678, 5, -1, 1'b0, 5, 1'b0, 32'h12345678, 1'b1};
        vecs[2] = '{21'h044,    32'h0,        1'b0, 1'b1, 32'h11111111, 0,  3, 1'b0, 8, 1'b1, 32'h0,        1'b1};
        vecs[3] = '{21'h044,    32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 8, -1, 1'b0, 8, 1'b0, 32'hCAFEF00D, 1'b1};
        vecs[4] = '{21'h0E2,    32'h5,        1'b1, 1'b1, 32'h0,        1, -1, 1'b0, 0, 1'b1, 32'h0,        1'b1};
        vecs[5] = '{21'h13F,    32'hA5A5A5A5, 1'b1, 1'b0, 32'hFFFFFFFF, 3, -1, 1'b0, 3, 1'b0, 32'h0,        1'b1};
        vecs[6] = '{21'h01F,    32'h0,        1'b0, 1'b1, 32'h0BADC0DE, 1, -1, 1'b0, 1, 1'b0, 32'h0BADC0DE, 1'b1};
        vecs[7] = '{21'h0A3,    32'h0,        1'b0, 1'b0, 32'h0,        0, -1, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        vecs[8] = '{21'h1000A3, 32'h0,        1'b0, 1'b1, 32'h55AA55AA, 2, -1, 1'b0, 2, 1'b0, 32'h55AA55AA, 1'b1};
        vecs[9] = '{21'h080,    32'h0,        1'b0, 1'b1, 32'h77777777, 3, -1, 1'b1, 3, 1'b0, 32'h77777777, 1'b1};

        reset = 1'b1; mmio_cs = 1'b1; mmio_read = 1'b1; mmio_write = 1'b0;
        mmio_address = 21'h0A3; mmio_write_data = 32'h0; slot_ack = '0; slot_rd = '0;

        @(posedge clock); @(negedge clock);
        check("rst_slot_cs_c1", slot_cs, 64'h0);
        @(posedge clock); @(negedge clock);
        check("rst_slot_cs", slot_cs, 64'h0);
        check("rst_slot_read", slot_read, 64'd0);
        check("rst_slot_write", slot_write, 64'd0);
        check("rst_reg_addr", slot_reg_addr, 64'd0);
        check("rst_wdata", slot_write_data, 64'd0);
        check("rst_rdata", mmio_read_data, 64'd0);
        check("rst_ready", mmio_ready, 64'd0);
        check("rst_error", mmio_error, 64'd0);
        reset = 1'b0;
        idle_inputs();
        started = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_idle_cs", slot_cs, 64'h0);
        end

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        check40 = 1'b1;
        range_case(21'h5A0, 1'b1, 1'b0, 1'b1, TOUT + 4);
        range_case(21'h060, 1'b1, 1'b1, 1'b1, 4);
        check("resp40_drained", q40.size(), 0);
        check40 = 1'b0;

        // Reset while an access is in flight
        @(posedge clock); #1;
        mmio_cs = 1'b1; mmio_read = 1'b1; mmio_address = 21'h140;
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        check("abort_cs_before", slot_cs, 64'd1 << 10);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_cs", slot_cs, 64'h0);
        check("abort_read", slot_read, 64'd0);
        check("abort_ready", mmio_ready, 64'd0);
        repeat (TOUT + 4) @(posedge clock);

        check("final_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
